// File: rtl/rr_channel_mux.sv
// N-to-1 channel multiplexer with a registered output stage, valid/ready on every
// port, and either fixed (Sel) or fair round-robin channel selection.
module rr_channel_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Mode,
  input  logic [SELW-1:0]           Sel,
  input  logic [CHANNELS*WIDTH-1:0] Din,
  input  logic [CHANNELS-1:0]       Din_Valid,
  output logic [CHANNELS-1:0]       Din_Ready,
  output logic [WIDTH-1:0]          Dout,
  output logic                      Dout_Valid,
  input  logic                      Dout_Ready,
  output logic [SELW-1:0]           Dout_Chan
);

  localparam logic [31:0] CH_U = CHANNELS;

  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic [SELW-1:0]  r_dout_chan;
  logic [SELW-1:0]  r_last_grant;

  logic             w_load_en;
  logic             w_sel_legal;
  logic             w_rr_hit;
  logic [SELW-1:0]  w_rr_chan;
  logic [SELW-1:0]  w_chosen;
  logic             w_legal;
  logic             w_grant_ok;
  logic             w_xfer;
  logic [WIDTH-1:0] w_din_sel;

  assign w_load_en   = ~r_dout_valid | Dout_Ready;
  assign w_sel_legal = (32'(Sel) < CH_U);

  // Search starts just after the last granted channel, so each valid channel
  // is served within CHANNELS transfers.
  always_comb begin
    int idx;
    w_rr_hit  = 1'b0;
    w_rr_chan = '0;
    idx       = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(r_last_grant) + k) % CHANNELS;
      if (!w_rr_hit && Din_Valid[idx]) begin
        w_rr_hit  = 1'b1;
        w_rr_chan = SELW'(idx);
      end
    end
  end

  assign w_chosen   = Mode ? w_rr_chan : Sel;
  assign w_legal    = Mode ? w_rr_hit : w_sel_legal;
  assign w_grant_ok = ~Reset & w_load_en & w_legal;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign Din_Ready[gi] = w_grant_ok & (w_chosen == SELW'(gi));
    end
  endgenerate

  assign w_xfer = |(Din_Ready & Din_Valid);

  always_comb begin
    w_din_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_chosen == SELW'(i)) w_din_sel = Din[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_chan  <= '0;
      r_last_grant <= SELW'(CHANNELS - 1);
    end else if (w_load_en) begin
      r_dout_valid <= w_xfer;
      if (w_xfer) begin
        r_dout      <= w_din_sel;
        r_dout_chan <= w_chosen;
        if (Mode) r_last_grant <= w_chosen;
      end
    end
  end

  assign Dout       = r_dout;
  assign Dout_Valid = r_dout_valid;
  assign Dout_Chan  = r_dout_chan;

endmodule

// File: tb/tb_rr_channel_mux.sv
// Bench for rr_channel_mux: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_rr_channel_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic           Clk = 1'b0;
  logic           Reset, Mode, Dout_Ready, Dout_Valid;
  logic [1:0]     Sel, Dout_Chan;
  logic [N*W-1:0] Din;
  logic [N-1:0]   Din_Valid, Din_Ready;
  logic [W-1:0]   Dout;

  logic           Reset3, Mode3, Dout_Ready3, Dout_Valid3;
  logic [1:0]     Sel3, Dout_Chan3;
  logic [3*W-1:0] Din3;
  logic [2:0]     Din_Valid3, Din_Ready3;
  logic [W-1:0]   Dout3;

  always #5 Clk = ~Clk;

  rr_channel_mux #(.WIDTH(W), .CHANNELS(N)) dut (
    .Clk(Clk), .Reset(Reset), .Mode(Mode), .Sel(Sel), .Din(Din),
    .Din_Valid(Din_Valid), .Din_Ready(Din_Ready), .Dout(Dout),
    .Dout_Valid(Dout_Valid), .Dout_Ready(Dout_Ready), .Dout_Chan(Dout_Chan)
  );

  rr_channel_mux #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .Clk(Clk), .Reset(Reset3), .Mode(Mode3), .Sel(Sel3), .Din(Din3),
    .Din_Valid(Din_Valid3), .Din_Ready(Din_Ready3), .Dout(Dout3),
    .Dout_Valid(Dout_Valid3), .Dout_Ready(Dout_Ready3), .Dout_Chan(Dout_Chan3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus for the next cycle
  bit           s_reset, s_mode, s_dready;
  int           s_sel;
  logic [N-1:0] s_valid;
  logic [W-1:0] s_din [N];

  // behavioural model of the output register and pointer
  bit           m_valid;
  logic [W-1:0] m_dout;
  int           m_chan;
  int           m_ptr;

  logic [N-1:0] seen_ready;
  logic [2:0]   seen_ready3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check readies mid-cycle, advance model, check outputs.
  task automatic step();
    int           ch;
    bit           hit, load, xfer;
    logic [N-1:0] er;
    Reset      = s_reset;
    Mode       = s_mode;
    Sel        = 2'(s_sel);
    Din_Valid  = s_valid;
    Dout_Ready = s_dready;
    for (int i = 0; i < N; i++) Din[i*W +: W] = s_din[i];
    #2;
    load = !m_valid || s_dready;
    ch   = 0;
    hit  = 0;
    if (!s_mode) begin
      ch  = s_sel;
      hit = (s_sel < N);
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!hit && s_valid[(m_ptr + k) % N]) begin
          hit = 1;
          ch  = (m_ptr + k) % N;
        end
      end
    end
    er = (s_reset || !load || !hit) ? '0 : N'(1 << ch);
    seen_ready  = Din_Ready;
    seen_ready3 = Din_Ready3;
    check("din_ready", 32'(Din_Ready), 32'(er));
    xfer = (er & s_valid) != 0;
    @(posedge Clk);
    #1;
    if (s_reset) begin
      m_valid = 0; m_dout = '0; m_chan = 0; m_ptr = N - 1;
    end else if (load) begin
      m_valid = xfer;
      if (xfer) begin
        m_dout = s_din[ch];
        m_chan = ch;
        if (s_mode) m_ptr = ch;
      end
    end
    check("dout_valid", 32'(Dout_Valid), 32'(m_valid));
    if (m_valid) begin
      check("dout", 32'(Dout), 32'(m_dout));
      check("dout_chan", 32'(Dout_Chan), 32'(m_chan));
    end
    $display("cyc t=%0t rst=%0b mode=%0b sel=%0d v=%b rdy=%b dv=%0b dout=%02h ch=%0d",
             $time, s_reset, s_mode, s_sel, s_valid, seen_ready, Dout_Valid, Dout, Dout_Chan);
  endtask

  initial begin
    s_reset = 1; s_mode = 0; s_sel = 0; s_valid = '0; s_dready = 1;
    for (int i = 0; i < N; i++) s_din[i] = '0;
    m_valid = 0; m_dout = '0; m_chan = 0; m_ptr = N - 1;
    Reset3 = 1; Mode3 = 0; Sel3 = 0; Din3 = '0; Din_Valid3 = '0; Dout_Ready3 = 1;
    @(posedge Clk);
    #1;

    // reset state
    step();
    check("rst_dout", 32'(Dout), 32'h0);
    check("rst_dout_chan", 32'(Dout_Chan), 32'h0);
    check("rst_dout_valid", 32'(Dout_Valid), 32'h0);
    s_reset = 0;
    Reset3  = 0;

    // fixed select of channel 2
    s_mode = 0; s_sel = 2; s_valid = 4'b0100; s_din[2] = 8'hA5;
    step();
    check("t1_ready", 32'(seen_ready), 32'h4);
    check("t1_dout", 32'(Dout), 32'hA5);
    check("t1_chan", 32'(Dout_Chan), 32'd2);
    check("t1_valid", 32'(Dout_Valid), 32'd1);

    // round-robin over all channels, no bubbles
    s_mode = 1; s_valid = 4'b1111;
    for (int i = 0; i < N; i++) s_din[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_chan", 32'(Dout_Chan), 32'(i % 4));
      check("t2_valid", 32'(Dout_Valid), 32'd1);
    end

    // round-robin over channels 1 and 3 only
    s_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_chan", 32'(Dout_Chan), (i % 2 == 0) ? 32'd1 : 32'd3);
      check("t3_ready", 32'(seen_ready), (i % 2 == 0) ? 32'h2 : 32'h8);
    end

    // stall holds the output word
    s_mode = 0; s_sel = 0; s_valid = 4'b0001; s_din[0] = 8'h3C;
    step();
    check("t4_load", 32'(Dout), 32'h3C);
    s_dready = 0;
    for (int i = 0; i < 3; i++) begin
      s_din[0] = 8'h50 + 8'(i);
      step();
      check("t4_hold", 32'(Dout), 32'h3C);
      check("t4_hold_valid", 32'(Dout_Valid), 32'd1);
      check("t4_ready0", 32'(seen_ready), 32'h0);
    end
    s_dready = 1; s_din[0] = 8'h77;
    step();
    check("t4_ready", 32'(seen_ready), 32'h1);
    check("t4_new", 32'(Dout), 32'h77);

    // reset mid-stream with pointer at 2
    s_mode = 1; s_valid = 4'b0100; s_din[2] = 8'h99;
    step();
    check("t6_chan", 32'(Dout_Chan), 32'd2);
    s_reset = 1; s_dready = 0;
    step();
    check("t6_dout", 32'(Dout), 32'h0);
    check("t6_valid", 32'(Dout_Valid), 32'h0);
    check("t6_chan0", 32'(Dout_Chan), 32'h0);
    check("t6_ready", 32'(seen_ready), 32'h0);
    s_reset = 0; s_dready = 1; s_valid = 4'b1111;
    step();
    check("t6_first", 32'(seen_ready), 32'h1);
    check("t6_first_chan", 32'(Dout_Chan), 32'd0);

    // three-channel instance: out-of-range select grants nothing
    Mode3 = 0; Sel3 = 1; Din_Valid3 = 3'b111; Din3 = 24'hC3B2A1; Dout_Ready3 = 1;
    step();
    check("t5_load_valid", 32'(Dout_Valid3), 32'd1);
    check("t5_load_data", 32'(Dout3), 32'hB2);
    check("t5_load_chan", 32'(Dout_Chan3), 32'd1);
    Sel3 = 3;
    step();
    check("t5_ready", 32'(seen_ready3), 32'h0);
    check("t5_drain", 32'(Dout_Valid3), 32'd0);
    step();
    check("t5_ready_idle", 32'(seen_ready3), 32'h0);
    check("t5_idle", 32'(Dout_Valid3), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      s_reset  = ($urandom_range(0, 59) == 0);
      s_mode   = ($urandom_range(0, 3) != 0);
      s_sel    = $urandom_range(0, N - 1);
      s_valid  = N'($urandom);
      s_dready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) s_din[i] = W'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
